// File: rtl/spu_adsr_stepper.sv
// Per-voice SPU ADSR envelope engine: fetches the phase rate increment on each
// sample tick, accumulates it and applies whole volume steps to a 15-bit level.
module spu_adsr_stepper #(
   parameter int ACC_W    = 23,
   parameter int LIN_STEP = 32,
   parameter int EXP_KNEE = 24576
) (
   input  logic        m_clock,
   input  logic        p_reset,
   input  logic        tick,
   input  logic        key_on,
   input  logic        key_off,
   input  logic [6:0]  ar,
   input  logic        a_exp,
   input  logic [3:0]  dr,
   input  logic [3:0]  sl,
   input  logic [6:0]  sr,
   input  logic        s_dec,
   input  logic        s_exp,
   input  logic [4:0]  rr,
   input  logic        r_exp,
   output logic [6:0]  rt_adrs,
   output logic        rt_read,
   input  logic [20:0] rt_dout,
   output logic [14:0] env_vol,
   output logic [2:0]  env_phase,
   output logic        env_upd
);

   localparam int FRAC = 20;

   typedef enum logic [1:0] {
      S_IDLE, S_FETCH, S_WAIT, S_APPLY
   } seq_e;

   typedef enum logic [2:0] {
      PH_OFF     = 3'd0,
      PH_ATTACK  = 3'd1,
      PH_DECAY   = 3'd2,
      PH_SUSTAIN = 3'd3,
      PH_RELEASE = 3'd4
   } phase_e;

   seq_e               seq_q, seq_d;
   phase_e             phase_q, phase_d;
   logic [14:0]        vol_q, vol_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [20:0]        inc_q, inc_d;

   logic [ACC_W-1:0]   sum;
   logic [2:0]         carry;
   logic [14:0]        tgt;
   logic [14:0]        clamp;
   logic signed [16:0] vol_s, lin_s, exp_dn_s, up_exp_s, step_s, new_s;

   always_ff @(posedge m_clock or negedge p_reset) begin
      if (!p_reset) begin
         seq_q   <= S_IDLE;
         phase_q <= PH_OFF;
         vol_q   <= '0;
         acc_q   <= '0;
         inc_q   <= '0;
      end else begin
         seq_q   <= seq_d;
         phase_q <= phase_d;
         vol_q   <= vol_d;
         acc_q   <= acc_d;
         inc_q   <= inc_d;
      end
   end

   // Step size per unit of carry for the current phase and level.
   always_comb begin
      vol_s    = {2'b00, vol_q};
      lin_s    = 17'(LIN_STEP);
      exp_dn_s = 17'(vol_q[14:8]) + 17'sd1;
      up_exp_s = (vol_q < 15'(EXP_KNEE)) ? lin_s : 17'sd8;
      step_s   = 17'sd0;
      case (phase_q)
         PH_ATTACK:  step_s = a_exp ? up_exp_s : lin_s;
         PH_DECAY:   step_s = -exp_dn_s;
         PH_SUSTAIN: begin
            if (s_dec) step_s = s_exp ? -exp_dn_s : -lin_s;
            else       step_s = s_exp ? up_exp_s : lin_s;
         end
         PH_RELEASE: step_s = r_exp ? -exp_dn_s : -lin_s;
         default:    step_s = 17'sd0;
      endcase
      sum   = acc_q + ACC_W'(inc_q);
      carry = sum[ACC_W-1:FRAC];
      new_s = vol_s + step_s * $signed({14'd0, carry});
      if (new_s < 17'sd0)          clamp = 15'h0000;
      else if (new_s > 17'sd32767) clamp = 15'h7FFF;
      else                         clamp = new_s[14:0];
      tgt = {sl, 11'h7FF};
   end

   always_comb begin
      rt_adrs = 7'd0;
      case (phase_q)
         PH_ATTACK:  rt_adrs = ar;
         PH_DECAY:   rt_adrs = {dr, 3'b111};
         PH_SUSTAIN: rt_adrs = sr;
         PH_RELEASE: rt_adrs = {rr, 2'b11};
         default:    rt_adrs = 7'd0;
      endcase
   end

   always_comb begin
      seq_d   = seq_q;
      phase_d = phase_q;
      vol_d   = vol_q;
      acc_d   = acc_q;
      inc_d   = inc_q;
      rt_read = 1'b0;
      env_upd = 1'b0;
      unique case (seq_q)
         S_IDLE: begin
            if (tick && phase_q != PH_OFF) seq_d = S_FETCH;
         end
         S_FETCH: begin
            rt_read = (phase_q != PH_OFF);
            seq_d   = S_WAIT;
         end
         S_WAIT: begin
            inc_d = rt_dout;
            seq_d = S_APPLY;
         end
         S_APPLY: begin
            env_upd = 1'b1;
            seq_d   = S_IDLE;
            vol_d   = clamp;
            acc_d   = ACC_W'(sum[FRAC-1:0]);
            case (phase_q)
               PH_ATTACK: begin
                  if (clamp == 15'h7FFF) begin
                     phase_d = PH_DECAY;
                     acc_d   = '0;
                  end
               end
               PH_DECAY: begin
                  if (clamp <= tgt) begin
                     vol_d   = tgt;
                     phase_d = PH_SUSTAIN;
                     acc_d   = '0;
                  end
               end
               PH_RELEASE: begin
                  if (clamp == 15'h0000) begin
                     phase_d = PH_OFF;
                     acc_d   = '0;
                  end
               end
               default: ;
            endcase
         end
      endcase
      // Key events abort any fetch in flight and discard a pending update.
      if (key_on) begin
         seq_d   = S_IDLE;
         phase_d = PH_ATTACK;
         vol_d   = '0;
         acc_d   = '0;
         env_upd = 1'b0;
      end else if (key_off && phase_q != PH_OFF) begin
         seq_d   = S_IDLE;
         phase_d = PH_RELEASE;
         vol_d   = vol_q;
         acc_d   = '0;
         env_upd = 1'b0;
      end
   end

   assign env_vol   = vol_q;
   assign env_phase = phase_q;

endmodule

// File: tb/tb_spu_adsr_stepper.sv
// Directed bench for spu_adsr_stepper with a behavioural rate-table ROM.
module tb_spu_adsr_stepper;

   logic        m_clock = 1'b0;
   logic        p_reset = 1'b0;
   logic        tick = 1'b0, key_on = 1'b0, key_off = 1'b0;
   logic [6:0]  ar = '0, sr = '0;
   logic        a_exp = 1'b0, s_dec = 1'b0, s_exp = 1'b0, r_exp = 1'b0;
   logic [3:0]  dr = 4'hF, sl = 4'd7;
   logic [4:0]  rr = 5'h0C;
   logic [6:0]  rt_adrs;
   logic        rt_read;
   logic [20:0] rt_dout = '0;
   logic [14:0] env_vol;
   logic [2:0]  env_phase;
   logic        env_upd;

   logic [20:0] rom [128];
   int n_cmp = 0, n_err = 0;
   int rd_cnt = 0, upd_cnt = 0;

   spu_adsr_stepper dut (
      .m_clock(m_clock), .p_reset(p_reset), .tick(tick),
      .key_on(key_on), .key_off(key_off),
      .ar(ar), .a_exp(a_exp), .dr(dr), .sl(sl),
      .sr(sr), .s_dec(s_dec), .s_exp(s_exp),
      .rr(rr), .r_exp(r_exp),
      .rt_adrs(rt_adrs), .rt_read(rt_read), .rt_dout(rt_dout),
      .env_vol(env_vol), .env_phase(env_phase), .env_upd(env_upd)
   );

   always #5 m_clock = ~m_clock;

   always @(posedge m_clock) begin
      if (rt_read) rt_dout <= rom[rt_adrs];
      if (rt_read) rd_cnt <= rd_cnt + 1;
      if (env_upd) upd_cnt <= upd_cnt + 1;
   end

   typedef struct {
      bit          kon;
      logic [6:0]  a;
      bit          aexp;
      logic [20:0] inc;
      int          nt;
      logic [14:0] vol;
      logic [2:0]  ph;
   } vec_t;

   vec_t vt [12];

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic pulse_kon();
      @(posedge m_clock); #1 key_on = 1'b1;
      @(posedge m_clock); #1 key_on = 1'b0;
   endtask

   task automatic pulse_koff();
      @(posedge m_clock); #1 key_off = 1'b1;
      @(posedge m_clock); #1 key_off = 1'b0;
   endtask

   task automatic tick_start();
      @(posedge m_clock); #1 tick = 1'b1;
      @(posedge m_clock); #1 tick = 1'b0;
   endtask

   task automatic do_tick();
      int lat;
      lat = 0;
      tick_start();
      for (int n = 1; n <= 8; n++) begin
         @(negedge m_clock);
         if (env_upd) begin
            lat = n;
            break;
         end
      end
      n_cmp++;
      if (lat != 3) begin
         n_err++;
         $display("FAIL upd_latency: got %0d expected 3", lat);
      end
      @(posedge m_clock); #1;
   endtask

   task automatic tick_noupd(string nm);
      int r0, u0;
      r0 = rd_cnt;
      u0 = upd_cnt;
      tick_start();
      repeat (5) @(posedge m_clock);
      #1;
      chk({nm, "_rd"}, rd_cnt - r0, 0);
      chk({nm, "_upd"}, upd_cnt - u0, 0);
   endtask

   initial begin
      for (int i = 0; i < 128; i++) rom[i] = '0;
      vt[0]  = '{1, 7'h38, 0, 21'h1C0000, 1,    15'h0020, 3'd1};
      vt[1]  = '{0, 7'h38, 0, 21'h1C0000, 1,    15'h0060, 3'd1};
      vt[2]  = '{1, 7'h10, 1, 21'h100000, 3,    15'h0060, 3'd1};
      vt[3]  = '{1, 7'h11, 0, 21'h000000, 2,    15'h0000, 3'd1};
      vt[4]  = '{1, 7'h12, 0, 21'h080000, 1,    15'h0000, 3'd1};
      vt[5]  = '{0, 7'h12, 0, 21'h080000, 1,    15'h0020, 3'd1};
      vt[6]  = '{1, 7'h20, 1, 21'h100000, 768,  15'h6000, 3'd1};
      vt[7]  = '{0, 7'h20, 1, 21'h100000, 1,    15'h6008, 3'd1};
      vt[8]  = '{0, 7'h20, 1, 21'h100000, 1022, 15'h7FF8, 3'd1};
      vt[9]  = '{0, 7'h20, 1, 21'h100000, 1,    15'h7FFF, 3'd2};
      vt[10] = '{1, 7'h30, 0, 21'h100000, 1023, 15'h7FE0, 3'd1};
      vt[11] = '{0, 7'h30, 0, 21'h100000, 1,    15'h7FFF, 3'd2};

      repeat (2) @(posedge m_clock);
      #1;
      chk("rst_vol", env_vol, 0);
      chk("rst_phase", env_phase, 0);
      chk("rst_read", rt_read, 0);
      chk("rst_adrs", rt_adrs, 0);
      chk("rst_upd", env_upd, 0);
      p_reset = 1'b1;
      tick_noupd("off_tick");

      // Reset asserted while the sequencer sits in WAIT.
      ar = 7'h38;
      rom[7'h38] = 21'h1C0000;
      pulse_kon();
      do_tick();
      chk("pre_rst_vol", env_vol, 15'h0020);
      tick_start();
      @(posedge m_clock); #3 p_reset = 1'b0;
      #1;
      chk("midrst_vol", env_vol, 0);
      chk("midrst_phase", env_phase, 0);
      chk("midrst_read", rt_read, 0);
      chk("midrst_upd", env_upd, 0);
      @(posedge m_clock); #1 p_reset = 1'b1;
      tick_noupd("postrst_tick");

      for (int v = 0; v < 12; v++) begin
         ar = vt[v].a;
         a_exp = vt[v].aexp;
         rom[vt[v].a] = vt[v].inc;
         if (vt[v].kon) pulse_kon();
         for (int t = 0; t < vt[v].nt; t++) do_tick();
         chk($sformatf("vec%0d_vol", v), env_vol, vt[v].vol);
         chk($sformatf("vec%0d_phase", v), env_phase, vt[v].ph);
      end

      // Decay from full scale with a slow rate, then a forced fast one.
      rom[7'h7F] = 21'd8;
      repeat (3) do_tick();
      chk("dec_slow_vol", env_vol, 15'h7FFF);
      chk("dec_slow_phase", env_phase, 3'd2);
      rom[7'h7F] = 21'h100000;
      do_tick();
      chk("dec_step_vol", env_vol, 15'h7F7F);
      for (int i = 0; i < 500 && env_phase == 3'd2; i++) do_tick();
      chk("dec_end_phase", env_phase, 3'd3);
      chk("dec_end_vol", env_vol, 15'h3FFF);

      // Sustain down to the floor, hold there, then climb back up.
      sr = 7'h05;
      s_dec = 1'b1;
      rom[7'h05] = 21'h1FFFFF;
      for (int i = 0; i < 400 && env_vol != 0; i++) do_tick();
      chk("sus_floor_vol", env_vol, 0);
      do_tick();
      chk("sus_hold_vol", env_vol, 0);
      chk("sus_hold_phase", env_phase, 3'd3);
      s_dec = 1'b0;
      rom[7'h05] = 21'h100000;
      do_tick();
      chk("sus_up1_vol", env_vol, 15'h0020);
      do_tick();
      chk("sus_up2_vol", env_vol, 15'h0040);

      // Linear release to silence.
      rom[7'h33] = 21'h100000;
      pulse_koff();
      chk("rel_phase", env_phase, 3'd4);
      chk("rel_vol", env_vol, 15'h0040);
      do_tick();
      chk("rel1_vol", env_vol, 15'h0020);
      do_tick();
      chk("rel2_vol", env_vol, 0);
      chk("rel2_phase", env_phase, 3'd0);
      tick_noupd("rel_off_tick");

      // key_on together with key_off while a release fetch is in WAIT.
      ar = 7'h38;
      pulse_kon();
      do_tick();
      pulse_koff();
      chk("koff_phase", env_phase, 3'd4);
      chk("koff_vol", env_vol, 15'h0020);
      begin
         int u0;
         u0 = upd_cnt;
         tick_start();
         @(posedge m_clock); #1 key_on = 1'b1; key_off = 1'b1;
         @(posedge m_clock); #1 key_on = 1'b0; key_off = 1'b0;
         repeat (3) @(posedge m_clock);
         #1;
         chk("both_upd", upd_cnt - u0, 0);
         chk("both_phase", env_phase, 3'd1);
         chk("both_vol", env_vol, 0);
      end

      // key_off landing exactly on APPLY discards the update.
      do_tick();
      chk("ap_pre_vol", env_vol, 15'h0020);
      tick_start();
      @(posedge m_clock); #1;
      @(posedge m_clock); #1 key_off = 1'b1;
      @(negedge m_clock);
      chk("ap_koff_upd", env_upd, 0);
      @(posedge m_clock); #1 key_off = 1'b0;
      chk("ap_koff_phase", env_phase, 3'd4);
      chk("ap_koff_vol", env_vol, 15'h0020);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule
